spi_target: RTL and testbench

- SPI mode-0 target (slave): the other end of the card-side SPI bus that the host-side SPI controller drives.
- Sits in the controller-test and expansion fabric, so a CPLD/FPGA on the same board can answer the Amiga SPI master, for example as an SD-card model or a register bridge.
- Oversamples sclk, mosi and _cs with the system clock, and deserialises received bytes with a byte-valid pulse.
- Serialises transmit bytes through a one-deep holding register and keeps a bit-serial CRC16 of the received stream.

---
 rtl/spi_target_pkg.sv | 31 +++
 rtl/spi_target_crc16_serial.sv | 40 ++++
 rtl/spi_target.sv | 221 ++++++++++++++++++++++
 tb/tb_spi_target.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_target_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_target_pkg
// Description : Shared definitions for the SPI mode-0 target and the bit-serial
//               CRC16 engine: polynomial, default idle byte, FSM encoding and
//               a one-bit CRC16 step helper.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_target_pkg;

    // CRC16-CCITT polynomial, MSB first, no reflection.
    localparam logic [15:0] CRC16_POLY        = 16'h1021;

    // Byte returned to the master when nothing is queued (SD idle level).
    localparam logic [7:0]  DEFAULT_IDLE_BYTE = 8'hFF;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Advance a CRC16 by one input bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                               input logic        data_bit);
        logic fb;
        fb = crc[15] ^ data_bit;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage : spi_target_pkg
`default_nettype wire

// File: rtl/spi_target_crc16_serial.sv
`default_nettype none
// ============================================================================
// Module      : crc16_serial
// Description : Bit-serial CRC16 (poly 0x1021, MSB first). One bit is folded
//               in per clk while en is high; init reloads the seed.
// Ports       : clk, rst      - system clock, synchronous active-high reset
//               init          - load init_val (has priority over en)
//               init_val[15:0]- seed value, also the reset value
//               en, bit_in    - advance the CRC by bit_in
//               crc[15:0]     - current CRC register
// Revision    : 1.0 - initial release
// ============================================================================
module crc16_serial
    import spi_target_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic [15:0] init_val,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic [15:0] r_crc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc <= init_val;
        end else if (init) begin
            r_crc <= init_val;
        end else if (en) begin
            r_crc <= crc16_step(r_crc, bit_in);
        end
    end

    assign crc = r_crc;

endmodule : crc16_serial
`default_nettype wire

// File: rtl/spi_target.sv
`default_nettype none
// ============================================================================
// Module      : spi_target
// Description : SPI mode-0 target. sclk/mosi/_cs are oversampled by clk
//               (clk >= 4x sclk), received bytes are deserialised with a
//               one-clk valid pulse, transmit bytes come from a one-deep
//               holding register, and a CRC16 runs over every received bit.
// Ports       : clk, rst            - system clock, sync active-high reset
//               sclk, mosi, _cs     - asynchronous SPI pins from the master
//               miso, miso_oe       - registered data out and its enable
//               rx_data, rx_valid   - last received byte and update pulse
//               tx_data, tx_load    - byte to send and its write strobe
//               tx_ready            - holding register empty
//               tx_underrun         - IDLE_BYTE substituted (pulse)
//               frame_end           - _cs deasserted (pulse)
//               crc_out             - running CRC16 of received bits
// Revision    : 1.0 - initial release
// ============================================================================
module spi_target
    import spi_target_pkg::*;
#(
    parameter logic [7:0]  IDLE_BYTE = DEFAULT_IDLE_BYTE,
    parameter logic [15:0] CRC_INIT  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        _cs,
    output logic        miso,
    output logic        miso_oe,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic [7:0]  tx_data,
    input  logic        tx_load,
    output logic        tx_ready,
    output logic        tx_underrun,
    output logic        frame_end,
    output logic [15:0] crc_out
);

    // ------------------------------------------------------------------
    // Pin synchronisers: two flops each, plus a history flop on sclk and
    // _cs so edges are detected on already-synchronised levels.
    // ------------------------------------------------------------------
    logic r_sclk_meta, r_sclk_sync, r_sclk_hist;
    logic r_cs_meta,   r_cs_sync,   r_cs_hist;
    logic r_mosi_meta, r_mosi_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_hist <= 1'b0;
            r_cs_meta   <= 1'b1;
            r_cs_sync   <= 1'b1;
            r_cs_hist   <= 1'b1;
            r_mosi_meta <= 1'b1;
            r_mosi_sync <= 1'b1;
        end else begin
            r_sclk_meta <= sclk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_hist <= r_sclk_sync;
            r_cs_meta   <= _cs;
            r_cs_sync   <= r_cs_meta;
            r_cs_hist   <= r_cs_sync;
            r_mosi_meta <= mosi;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;

    assign w_sclk_rise =  r_sclk_sync & ~r_sclk_hist;
    assign w_sclk_fall = ~r_sclk_sync &  r_sclk_hist;
    assign w_cs_fall   = ~r_cs_sync   &  r_cs_hist;
    assign w_cs_rise   =  r_cs_sync   & ~r_cs_hist;

    // ------------------------------------------------------------------
    // Frame FSM. The strobes it produces are the only way the datapath
    // reacts to the bus, so deselect automatically masks a coincident
    // sclk edge.
    // ------------------------------------------------------------------
    state_t r_state, w_state_next;
    logic   w_select, w_deselect, w_rise, w_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_select     = 1'b0;
        w_deselect   = 1'b0;
        w_rise       = 1'b0;
        w_fall       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_next = ST_ACTIVE;
                    w_select     = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_next = ST_IDLE;
                    w_deselect   = 1'b1;
                end else begin
                    w_rise = w_sclk_rise;
                    w_fall = w_sclk_fall;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [2:0] r_bit_cnt;
    logic [6:0] r_rx_shift;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic [6:0] r_tx_shift;   // bit 7 of the current byte lives in r_miso
    logic       r_miso;
    logic       r_hold_full;
    logic [7:0] r_hold_data;
    logic       r_tx_underrun;
    logic       r_frame_end;

    logic       w_reload;
    logic       w_consume;
    logic       w_load_accept;
    logic [7:0] w_tx_next;
    logic [7:0] w_rx_next;

    // A new transmit byte is fetched at select and at every falling edge
    // that follows a completed byte.
    assign w_reload      = w_select | (w_fall & (r_bit_cnt == 3'd0));
    assign w_consume     = w_reload & r_hold_full;
    // A load is only accepted when the register was already empty before
    // this clk; a same-clk consumption does not make room for it.
    assign w_load_accept = tx_load & ~r_hold_full;
    assign w_tx_next     = r_hold_full ? r_hold_data : IDLE_BYTE;
    assign w_rx_next     = {r_rx_shift, r_mosi_sync};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt     <= 3'd0;
            r_rx_shift    <= 7'd0;
            r_rx_data     <= 8'd0;
            r_rx_valid    <= 1'b0;
            r_tx_shift    <= 7'd0;
            r_miso        <= 1'b1;
            r_hold_full   <= 1'b0;
            r_hold_data   <= 8'd0;
            r_tx_underrun <= 1'b0;
            r_frame_end   <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_frame_end   <= w_deselect;

            if (w_load_accept) begin
                r_hold_full <= 1'b1;
                r_hold_data <= tx_data;
            end else if (w_consume) begin
                r_hold_full <= 1'b0;
            end

            if (w_reload) begin
                r_tx_shift    <= w_tx_next[6:0];
                r_miso        <= w_tx_next[7];
                r_tx_underrun <= ~r_hold_full;
            end else if (w_fall) begin
                r_tx_shift <= {r_tx_shift[5:0], 1'b0};
                r_miso     <= r_tx_shift[6];
            end

            if (w_select || w_deselect) begin
                r_bit_cnt <= 3'd0;
                if (w_deselect) begin
                    r_miso <= 1'b1;
                end
            end else if (w_rise) begin
                r_rx_shift <= w_rx_next[6:0];
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_rx_data  <= w_rx_next;
                    r_rx_valid <= 1'b1;
                end
            end
        end
    end

    // CRC is updated on the same clk edge that captures rx_data, so
    // crc_out already covers a byte when its rx_valid is seen.
    crc16_serial u_crc (
        .clk      (clk),
        .rst      (rst),
        .init     (w_select),
        .init_val (CRC_INIT),
        .en       (w_rise),
        .bit_in   (r_mosi_sync),
        .crc      (crc_out)
    );

    assign miso        = r_miso;
    assign miso_oe     = (r_state == ST_ACTIVE);
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_ready    = ~r_hold_full;
    assign tx_underrun = r_tx_underrun;
    assign frame_end   = r_frame_end;

endmodule : spi_target
`default_nettype wire

// File: tb/tb_spi_target.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_target
// Description : Self-checking bench for spi_target. A mode-0 master is driven
//               at clk/8; table vectors cover single-byte frames and directed
//               sequences cover multi-byte, partial, reload and reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_target;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk, mosi, cs_n;
    logic        miso, miso_oe;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_load;
    logic        tx_ready, tx_underrun, frame_end;
    logic [15:0] crc_out;

    always #5 clk = ~clk;

    spi_target #(
        .IDLE_BYTE (8'hFF),
        .CRC_INIT  (16'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk),
        .mosi        (mosi),
        ._cs         (cs_n),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .tx_ready    (tx_ready),
        .tx_underrun (tx_underrun),
        .frame_end   (frame_end),
        .crc_out     (crc_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse counters and captures, sampled away from the active edge.
    int          rx_cnt  = 0;
    int          unr_cnt = 0;
    int          fe_cnt  = 0;
    logic [7:0]  last_rx  = 8'h00;
    logic [15:0] last_crc = 16'h0000;

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_cnt   = rx_cnt + 1;
            last_rx  = rx_data;
            last_crc = crc_out;
        end
        if (tx_underrun) unr_cnt = unr_cnt + 1;
        if (frame_end)   fe_cnt  = fe_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode-0 master: data set while sclk low, miso sampled just before rise.
    task automatic spi_bits(input logic [7:0] b, input int nbits,
                            output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            tick(4);
            got  = {got[6:0], miso};
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
    endtask

    task automatic select_frame();
        cs_n = 1'b0;
        tick(8);
    endtask

    task automatic deselect_frame();
        tick(4);
        cs_n = 1'b1;
        tick(8);
    endtask

    task automatic load_tx(input logic [7:0] b);
        tx_data = b;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
    endtask

    typedef struct {
        logic       preload;
        logic [7:0] tx;
        logic [7:0] mo;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
        int         exp_unr;   // the closing falling edge always reloads once
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [7:0] got;
        int rx0, unr0, fe0;
        logic [7:0] msg [9];

        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'h3C, 8'hA5, 1};
        vecs[1] = '{1'b1, 8'h00, 8'hFF, 8'hFF, 8'h00, 1};
        vecs[2] = '{1'b0, 8'h00, 8'h5A, 8'h5A, 8'hFF, 2};
        vecs[3] = '{1'b1, 8'hC3, 8'h81, 8'h81, 8'hC3, 1};
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

        rst = 1'b1; sclk = 1'b0; mosi = 1'b1; cs_n = 1'b1;
        tx_data = 8'h00; tx_load = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(2);

        // Reset state
        check("reset_miso",     miso,     1);
        check("reset_miso_oe",  miso_oe,  0);
        check("reset_tx_ready", tx_ready, 1);
        check("reset_crc",      crc_out,  16'h0000);
        check("reset_rx_data",  rx_data,  8'h00);

        // sclk toggling while deselected is ignored
        rx0 = rx_cnt;
        spi_bits(8'h55, 8, got);
        tick(6);
        check("idle_no_rx_valid", rx_cnt - rx0, 0);
        check("idle_miso_oe",     miso_oe,      0);

        // Table-driven single-byte frames
        for (int v = 0; v < 4; v++) begin
            rx0 = rx_cnt; unr0 = unr_cnt; fe0 = fe_cnt;
            if (vecs[v].preload) load_tx(vecs[v].tx);
            select_frame();
            check($sformatf("v%0d_miso_oe", v), miso_oe, 1);
            spi_bits(vecs[v].mo, 8, got);
            deselect_frame();
            check($sformatf("v%0d_rx_cnt", v),   rx_cnt - rx0,     1);
            check($sformatf("v%0d_rx_data", v),  last_rx,          vecs[v].exp_rx);
            check($sformatf("v%0d_miso", v),     got,              vecs[v].exp_miso);
            check($sformatf("v%0d_underrun", v), unr_cnt - unr0,   vecs[v].exp_unr);
            check($sformatf("v%0d_tx_ready", v), tx_ready,         1);
            check($sformatf("v%0d_frame_end", v), fe_cnt - fe0,    1);
            check($sformatf("v%0d_oe_off", v),   miso_oe,          0);
        end

        // Two-byte frame, only the first byte queued
        unr0 = unr_cnt;
        load_tx(8'h3C);
        select_frame();
        spi_bits(8'h00, 8, got);
        check("two_b1_miso", got, 8'h3C);
        tick(4);
        check("two_boundary_underrun", unr_cnt - unr0, 1);
        spi_bits(8'h00, 8, got);
        check("two_b2_miso", got, 8'hFF);
        deselect_frame();

        // CRC16 over "123456789"
        rx0 = rx_cnt;
        select_frame();
        for (int k = 0; k < 9; k++) spi_bits(msg[k], 8, got);
        deselect_frame();
        check("crc_rx_cnt",     rx_cnt - rx0, 9);
        check("crc_at_valid",   last_crc,     16'h31C3);
        check("crc_last_byte",  last_rx,      8'h39);
        check("crc_hold_idle",  crc_out,      16'h31C3);

        // Partial byte discarded, next frame restarts cleanly
        rx0 = rx_cnt; fe0 = fe_cnt;
        select_frame();
        spi_bits(8'hA0, 5, got);
        deselect_frame();
        check("partial_frame_end", fe_cnt - fe0, 1);
        check("partial_no_rx",     rx_cnt - rx0, 0);
        check("partial_oe",        miso_oe,      0);
        check("partial_miso",      miso,         1);
        select_frame();
        spi_bits(8'h81, 8, got);
        deselect_frame();
        check("after_partial_rx_cnt", rx_cnt - rx0, 1);
        check("after_partial_rx",     last_rx,      8'h81);

        // Second load while full is ignored
        load_tx(8'h11);
        load_tx(8'h22);
        check("dbl_tx_ready", tx_ready, 0);
        select_frame();
        spi_bits(8'h00, 8, got);
        deselect_frame();
        check("dbl_miso", got, 8'h11);

        // Reset mid-byte
        load_tx(8'h77);
        select_frame();
        spi_bits(8'hFF, 3, got);
        rst = 1'b1;
        tick(1);
        check("rst_miso",     miso,     1);
        check("rst_miso_oe",  miso_oe,  0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_data",  rx_data,  8'h00);
        check("rst_crc",      crc_out,  16'h0000);
        cs_n = 1'b1; sclk = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(4);
        select_frame();
        spi_bits(8'h00, 8, got);
        deselect_frame();
        check("rst_pending_lost", got, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule : tb_spi_target
`default_nettype wire
